// File: rtl/bike_counter_inc_seq_if.sv
// Bundle of control, data and status signals for the bike counter sequencer.
// The master side (the controller/bench) drives requests and reads status;
// the slave side (the counter) does the opposite.
interface bike_counter_inc_seq_if #(
    parameter int SIZE = 5
);
    logic            start;
    logic            enable;
    logic            load;
    logic [SIZE-1:0] load_val;
    logic            abort;
    logic [SIZE-1:0] cnt_out;
    logic            busy;
    logic            last;
    logic            done;

    modport master (
        output start, enable, load, load_val, abort,
        input  cnt_out, busy, last, done
    );

    modport slave (
        input  start, enable, load, load_val, abort,
        output cnt_out, busy, last, done
    );
endinterface

// File: rtl/bike_counter_inc_seq.sv
// Incrementing counter sequencer: a start request launches a run that steps
// the count by STEP on each enabled cycle until the next step would pass
// MAX_VALUE. The run then ends through a one-cycle DONE state, which raises
// done. Load overwrites the count, clamped to MAX_VALUE. Abort drops back to
// idle without signalling done.
module bike_counter_inc_seq #(
    parameter int SIZE      = 5,
    parameter int INIT      = 1,
    parameter int MAX_VALUE = 16,
    parameter int STEP      = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    bike_counter_inc_seq_if.slave  bus
);

    // Reject parameter sets the datapath cannot represent.
    if (longint'(MAX_VALUE) >= (longint'(1) << SIZE)) begin : g_bad_max
        $error("bike_counter_inc_seq: MAX_VALUE must be below 2**SIZE");
    end
    if (INIT > MAX_VALUE) begin : g_bad_init
        $error("bike_counter_inc_seq: INIT must not exceed MAX_VALUE");
    end
    if (STEP < 1) begin : g_bad_step
        $error("bike_counter_inc_seq: STEP must be at least 1");
    end

    localparam logic [SIZE-1:0] INIT_V = SIZE'(INIT);
    localparam logic [SIZE-1:0] MAX_V  = SIZE'(MAX_VALUE);
    // One bit wider than the count, so the sum cannot wrap.
    localparam logic [SIZE:0]   STEP_W = (SIZE+1)'(STEP);
    localparam logic [SIZE:0]   MAX_W  = (SIZE+1)'(MAX_VALUE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [SIZE-1:0] cnt_q;
    logic [SIZE-1:0] cnt_d;
    logic            busy_q;
    logic            done_q;

    logic [SIZE:0]   next_val;
    logic            over;
    logic [SIZE-1:0] load_sat;

    // Candidate next count and the two comparisons the FSM depends on.
    always_comb begin
        next_val = {1'b0, cnt_q} + STEP_W;
        over     = (next_val > MAX_W);
        load_sat = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
    end

    // Next-state and next-count selection; abort beats load, load beats enable.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = INIT_V;
                if (bus.start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    cnt_d   = INIT_V;
                    state_d = S_IDLE;
                end else if (bus.load) begin
                    cnt_d = load_sat;
                end else if (bus.enable) begin
                    if (over) begin
                        cnt_d   = INIT_V;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = next_val[SIZE-1:0];
                    end
                end
            end
            S_DONE: begin
                // Abort here leads to the same place, so it needs no branch.
                cnt_d   = INIT_V;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = INIT_V;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, count and the registered status flags.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the values from before the clock edge.
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= INIT_V;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign bus.cnt_out = cnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    // Combinational look-ahead: the next enabled cycle ends the run.
    assign bus.last    = busy_q & over;

endmodule

// File: tb/tb_bike_counter_inc_seq.sv
// Bench for bike_counter_inc_seq. Directed scenarios check fixed expected
// values. A random run is checked against a behavioural model of the
// sequencing rules. A second instance with STEP=5 checks coarse stepping.
module tb_bike_counter_inc_seq;

    localparam int SIZE = 5;
    localparam int INIT = 1;
    localparam int MAX  = 16;

    logic clk    = 1'b0;
    logic resetn = 1'b1;

    always #5 clk = ~clk;

    bike_counter_inc_seq_if #(.SIZE(SIZE)) a_if ();
    bike_counter_inc_seq_if #(.SIZE(SIZE)) b_if ();

    bike_counter_inc_seq #(
        .SIZE(SIZE), .INIT(INIT), .MAX_VALUE(MAX), .STEP(1)
    ) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (a_if.slave)
    );

    bike_counter_inc_seq #(
        .SIZE(SIZE), .INIT(INIT), .MAX_VALUE(MAX), .STEP(5)
    ) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (b_if.slave)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model of dut_a (STEP=1): running flag, done flag, count.
    int m_cnt;
    bit m_run;
    bit m_done;

    function automatic void model_reset();
        m_cnt  = INIT;
        m_run  = 1'b0;
        m_done = 1'b0;
    endfunction

    // Applies one clock edge's worth of rules using the current inputs.
    function automatic void model_step();
        if (m_run) begin
            if (a_if.abort) begin
                m_cnt = INIT;
                m_run = 1'b0;
            end else if (a_if.load) begin
                m_cnt = (int'(a_if.load_val) > MAX) ? MAX : int'(a_if.load_val);
            end else if (a_if.enable) begin
                if (m_cnt + 1 > MAX) begin
                    m_cnt  = INIT;
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end else if (m_done) begin
            m_done = 1'b0;
            m_cnt  = INIT;
        end else if (a_if.start) begin
            m_run = 1'b1;
        end
    endfunction

    // One clock: advance the model, then sample 1 ns after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_if.start = 1'b0; a_if.enable = 1'b0; a_if.load = 1'b0;
        a_if.abort = 1'b0; a_if.load_val = '0;
        b_if.start = 1'b0; b_if.enable = 1'b0; b_if.load = 1'b0;
        b_if.abort = 1'b0; b_if.load_val = '0;
    endtask

    task automatic test_reset();
        #1 resetn = 1'b0;
        #1;
        total++;
        if (a_if.cnt_out !== 5'd1 || a_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_cnt_busy: got cnt=%0d busy=%b, want cnt=1 busy=0",
                     a_if.cnt_out, a_if.busy);
        end
        total++;
        if (a_if.done !== 1'b0 || a_if.last !== 1'b0) begin
            bad++;
            $display("FAIL reset_done_last: got done=%b last=%b, want 0 0",
                     a_if.done, a_if.last);
        end
        #10 resetn = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_seq();
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        total++;
        if (a_if.cnt_out !== 5'd1 || a_if.busy !== 1'b1 || a_if.last !== 1'b0) begin
            bad++;
            $display("FAIL seq_start: got cnt=%0d busy=%b last=%b, want 1 1 0",
                     a_if.cnt_out, a_if.busy, a_if.last);
        end
        a_if.enable = 1'b1;
        for (int v = 2; v <= 16; v++) begin
            tick();
            total++;
            if (a_if.cnt_out !== 5'(v) || a_if.last !== (v == 16) || a_if.busy !== 1'b1) begin
                bad++;
                $display("FAIL seq_count: got cnt=%0d last=%b busy=%b, want cnt=%0d last=%b busy=1",
                         a_if.cnt_out, a_if.last, a_if.busy, v, (v == 16));
            end
        end
        tick();
        total++;
        if (a_if.cnt_out !== 5'd1 || a_if.done !== 1'b1 || a_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL seq_done: got cnt=%0d done=%b busy=%b, want 1 1 0",
                     a_if.cnt_out, a_if.done, a_if.busy);
        end
        tick();
        total++;
        if (a_if.done !== 1'b0 || a_if.busy !== 1'b0 || a_if.cnt_out !== 5'd1) begin
            bad++;
            $display("FAIL seq_idle: got cnt=%0d done=%b busy=%b, want 1 0 0",
                     a_if.cnt_out, a_if.done, a_if.busy);
        end
        a_if.enable = 1'b0;
    endtask

    task automatic test_step5();
        int exp_seq[3] = '{6, 11, 16};
        b_if.start = 1'b1;
        tick();
        b_if.start = 1'b0;
        total++;
        if (b_if.cnt_out !== 5'd1 || b_if.busy !== 1'b1) begin
            bad++;
            $display("FAIL step5_start: got cnt=%0d busy=%b, want 1 1",
                     b_if.cnt_out, b_if.busy);
        end
        b_if.enable = 1'b1;
        foreach (exp_seq[i]) begin
            tick();
            total++;
            if (b_if.cnt_out !== 5'(exp_seq[i]) || b_if.last !== (exp_seq[i] == 16)) begin
                bad++;
                $display("FAIL step5_count: got cnt=%0d last=%b, want cnt=%0d last=%b",
                         b_if.cnt_out, b_if.last, exp_seq[i], (exp_seq[i] == 16));
            end
        end
        tick();
        total++;
        if (b_if.cnt_out !== 5'd1 || b_if.done !== 1'b1 || b_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL step5_done: got cnt=%0d done=%b busy=%b, want 1 1 0",
                     b_if.cnt_out, b_if.done, b_if.busy);
        end
        tick();
        total++;
        if (b_if.done !== 1'b0 || b_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL step5_idle: got done=%b busy=%b, want 0 0",
                     b_if.done, b_if.busy);
        end
        b_if.enable = 1'b0;
    endtask

    task automatic test_load();
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        a_if.enable = 1'b1;
        a_if.load = 1'b1;
        a_if.load_val = 5'd20;
        tick();
        total++;
        if (a_if.cnt_out !== 5'd16 || a_if.last !== 1'b1 || a_if.busy !== 1'b1) begin
            bad++;
            $display("FAIL load_clamp: got cnt=%0d last=%b busy=%b, want 16 1 1",
                     a_if.cnt_out, a_if.last, a_if.busy);
        end
        a_if.load_val = 5'd7;
        tick();
        total++;
        if (a_if.cnt_out !== 5'd7 || a_if.last !== 1'b0) begin
            bad++;
            $display("FAIL load_7: got cnt=%0d last=%b, want 7 0",
                     a_if.cnt_out, a_if.last);
        end
        a_if.load = 1'b0;
        a_if.enable = 1'b0;
        tick();
        total++;
        if (a_if.cnt_out !== 5'd7 || a_if.busy !== 1'b1) begin
            bad++;
            $display("FAIL hold: got cnt=%0d busy=%b, want 7 1",
                     a_if.cnt_out, a_if.busy);
        end
        a_if.abort = 1'b1;
        tick();
        a_if.abort = 1'b0;
        total++;
        if (a_if.cnt_out !== 5'd1 || a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin
            bad++;
            $display("FAIL load_abort: got cnt=%0d busy=%b done=%b, want 1 0 0",
                     a_if.cnt_out, a_if.busy, a_if.done);
        end
    endtask

    task automatic test_abort_load();
        bit done_seen = 1'b0;
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        a_if.enable = 1'b1;
        repeat (8) tick();
        total++;
        if (a_if.cnt_out !== 5'd9) begin
            bad++;
            $display("FAIL abort_pre: got cnt=%0d, want 9", a_if.cnt_out);
        end
        a_if.abort = 1'b1;
        a_if.load = 1'b1;
        a_if.load_val = 5'd3;
        tick();
        a_if.abort = 1'b0;
        a_if.load = 1'b0;
        total++;
        if (a_if.cnt_out !== 5'd1 || a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin
            bad++;
            $display("FAIL abort_load: got cnt=%0d busy=%b done=%b, want 1 0 0",
                     a_if.cnt_out, a_if.busy, a_if.done);
        end
        // Enable stays high in idle and must have no effect.
        repeat (3) begin
            tick();
            if (a_if.done !== 1'b0 || a_if.cnt_out !== 5'd1 || a_if.busy !== 1'b0)
                done_seen = 1'b1;
        end
        total++;
        if (done_seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_quiet: got activity after abort=%b, want 0", done_seen);
        end
        a_if.enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit moved = 1'b0;
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        a_if.enable = 1'b1;
        repeat (11) tick();
        total++;
        if (a_if.cnt_out !== 5'd12) begin
            bad++;
            $display("FAIL rstmid_pre: got cnt=%0d, want 12", a_if.cnt_out);
        end
        #2 resetn = 1'b0;
        #1;
        total++;
        if (a_if.cnt_out !== 5'd1 || a_if.busy !== 1'b0 || a_if.last !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async: got cnt=%0d busy=%b last=%b, want 1 0 0",
                     a_if.cnt_out, a_if.busy, a_if.last);
        end
        #2 resetn = 1'b1;
        model_reset();
        repeat (3) begin
            tick();
            if (a_if.cnt_out !== 5'd1 || a_if.busy !== 1'b0 || a_if.done !== 1'b0)
                moved = 1'b1;
        end
        total++;
        if (moved !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_nostart: got activity without start=%b, want 0", moved);
        end
        a_if.enable = 1'b0;
    endtask

    task automatic test_random();
        int enabled = 0;
        for (int c = 0; c < 100; c++) begin
            a_if.enable   = 1'($urandom_range(0, 1));
            a_if.start    = ($urandom_range(0, 3) == 0);
            a_if.load     = ($urandom_range(0, 11) == 0);
            a_if.load_val = 5'($urandom_range(0, 31));
            a_if.abort    = ($urandom_range(0, 39) == 0);
            if (m_run && a_if.enable && !a_if.load && !a_if.abort) enabled++;
            tick();
            total++;
            if (a_if.cnt_out !== 5'(m_cnt) || a_if.busy !== m_run ||
                a_if.done !== m_done || a_if.last !== (m_run && (m_cnt + 1 > MAX))) begin
                bad++;
                $display("FAIL random c=%0d: got cnt=%0d busy=%b done=%b last=%b, want cnt=%0d busy=%b done=%b last=%b",
                         c, a_if.cnt_out, a_if.busy, a_if.done, a_if.last,
                         m_cnt, m_run, m_done, (m_run && (m_cnt + 1 > MAX)));
            end
        end
        idle_inputs();
        a_if.abort = 1'b1;
        tick();
        a_if.abort = 1'b0;
        tick();
        total++;
        if (a_if.busy !== 1'b0 || a_if.cnt_out !== 5'd1) begin
            bad++;
            $display("FAIL random_end: got busy=%b cnt=%0d after %0d enabled cycles, want 0 1",
                     a_if.busy, a_if.cnt_out, enabled);
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_full_seq();
        test_step5();
        test_load();
        test_abort_load();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
